// File: rtl/oled_pkg.sv
// Shared definitions for the OLED text refresher: FSM encoding, geometry
// constants and frame character lookup.
package oled_pkg;

  localparam int CHAR_PX     = 8;
  localparam int ROW_AW      = 2;
  localparam int X_AW        = 7;
  localparam int MAX_ROWS    = 4;
  localparam int MAX_COLS    = 16;
  localparam int FRAME_MAX_W = MAX_ROWS * MAX_COLS * CHAR_PX;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [3:0] {
    S_OFF, S_PWR_ON, S_IDLE, S_LOAD, S_WRITE,
    S_WWAIT, S_UPD, S_UWAIT, S_PWR_OFF, S_OFFW
  } state_t;

  // Row 0 / column 0 sits in the most significant byte of the frame.
  function automatic logic [7:0] char_at(input logic [FRAME_MAX_W-1:0] frame,
                                         input int rows, input int cols,
                                         input int r, input int c);
    return frame[((rows - 1 - r) * cols + cols - 1 - c) * CHAR_PX +: CHAR_PX];
  endfunction

endpackage

// File: rtl/oled_text_refresher_if.sv
// Command/handshake bundle between the text refresher and OLEDCtrl.
interface oled_text_refresher_if;
  import oled_pkg::*;

  logic                     write_start;
  logic [7:0]               write_ascii_data;
  logic [ROW_AW+X_AW-1:0]   write_base_addr;
  logic                     write_ready;
  logic                     update_start;
  logic                     update_clear;
  logic                     update_ready;
  logic                     disp_on_start;
  logic                     disp_off_start;
  logic                     disp_on_ready;
  logic                     disp_off_ready;

  modport master (
    output write_start, write_ascii_data, write_base_addr,
           update_start, update_clear, disp_on_start, disp_off_start,
    input  write_ready, update_ready, disp_on_ready, disp_off_ready
  );

  modport slave (
    input  write_start, write_ascii_data, write_base_addr,
           update_start, update_clear, disp_on_start, disp_off_start,
    output write_ready, update_ready, disp_on_ready, disp_off_ready
  );
endinterface

// File: rtl/oled_row_dirty.sv
// Per-row dirty tracking: compares incoming text against what the panel shows
// and picks the lowest row still needing a rewrite.
module oled_row_dirty
  import oled_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         text_valid,
  input  logic [ROWS*COLS*CHAR_PX-1:0] text_in,
  input  logic [ROWS*COLS*CHAR_PX-1:0] shown,
  input  logic                         force_all,
  input  logic                         clr_en,
  input  logic [ROW_AW-1:0]            clr_row,
  output logic [ROWS-1:0]              dirty,
  output logic                         any_dirty,
  output logic [ROW_AW-1:0]            low_row
);

  localparam int ROW_W = COLS * CHAR_PX;

  logic [ROWS-1:0] diff;
  logic [ROWS-1:0] dirty_nxt;

  always_comb begin
    diff = '0;
    for (int r = 0; r < ROWS; r++)
      diff[r] = text_in[(ROWS-1-r)*ROW_W +: ROW_W] != shown[(ROWS-1-r)*ROW_W +: ROW_W];
  end

  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (dirty[r]) low_row = ROW_AW'(r);
  end

  assign any_dirty = |dirty;

  // A fresh mismatch in the same cycle as the claim keeps the row dirty.
  always_comb begin
    dirty_nxt = dirty;
    if (clr_en)     dirty_nxt[clr_row] = 1'b0;
    if (text_valid) dirty_nxt = dirty_nxt | diff;
    if (force_all)  dirty_nxt = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) dirty <= '1;
    else     dirty <= dirty_nxt;
  end

endmodule

// File: rtl/oled_text_refresher.sv
// Keeps a ROWSxCOLS ASCII frame in sync with an OLEDCtrl panel, rewriting
// only changed rows, and sequences power-on/off, clear and forced refresh.
module oled_text_refresher
  import oled_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 16,
  parameter bit AUTO_START  = 1'b1,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROWS*COLS*CHAR_PX-1:0] text_in,
  input  logic                         text_valid,
  input  logic                         force_update,
  input  logic                         clear_req,
  input  logic                         disp_enable,
  oled_text_refresher_if.master        ctrl,
  output logic                         busy,
  output logic [ROWS-1:0]              dirty_rows,
  output logic [15:0]                  frame_count
);

  localparam int FRAME_W = ROWS * COLS * CHAR_PX;
  localparam state_t RST_STATE = AUTO_START ? S_PWR_ON : S_OFF;
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t state, state_nxt;
  logic [FRAME_W-1:0]      pend, shown;
  logic [ROW_AW-1:0]       row_q, ld_row, low_row;
  logic [3:0]              col_q, ld_col;
  logic [7:0]              data_q;
  logic [ROW_AW+X_AW-1:0]  addr_q;
  logic clear_pend, on_issued, any_dirty;
  logic load_char, row_claim, char_done, upd_done;
  logic wr_go, upd_go, on_go, off_go;

  oled_row_dirty #(.ROWS(ROWS), .COLS(COLS)) u_dirty (
    .clk(clk), .rst(rst), .text_valid(text_valid), .text_in(text_in),
    .shown(shown), .force_all(force_update), .clr_en(row_claim),
    .clr_row(low_row), .dirty(dirty_rows), .any_dirty(any_dirty),
    .low_row(low_row)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_go = 1'b0; upd_go = 1'b0; on_go = 1'b0; off_go = 1'b0;
    load_char = 1'b0; row_claim = 1'b0; char_done = 1'b0; upd_done = 1'b0;
    ld_row = row_q; ld_col = col_q;
    if (!rst) begin
      unique case (state)
        S_OFF:
          if (disp_enable && ctrl.disp_on_ready) begin
            on_go = 1'b1; state_nxt = S_PWR_ON;
          end
        // Entered straight from reset with AUTO_START, the power-on command
        // has not been issued yet, so send it here before waiting.
        S_PWR_ON:
          if (!on_issued) on_go = ctrl.disp_on_ready;
          else if (ctrl.disp_on_ready && ctrl.write_ready) state_nxt = S_IDLE;
        S_IDLE:
          if (!disp_enable)   state_nxt = S_PWR_OFF;
          else if (clear_pend) state_nxt = S_UPD;
          else if (any_dirty)  state_nxt = S_LOAD;
        S_LOAD: begin
          row_claim = 1'b1; load_char = 1'b1;
          ld_row = low_row; ld_col = '0;
          state_nxt = S_WRITE;
        end
        S_WRITE:
          if (ctrl.write_ready) begin wr_go = 1'b1; state_nxt = S_WWAIT; end
        S_WWAIT:
          if (ctrl.write_ready) begin
            char_done = 1'b1;
            if (col_q == LAST_COL) begin
              if (any_dirty)        state_nxt = S_LOAD;
              else if (AUTO_UPDATE) state_nxt = S_UPD;
              else                  state_nxt = S_IDLE;
            end else begin
              load_char = 1'b1; ld_col = col_q + 4'd1; state_nxt = S_WRITE;
            end
          end
        S_UPD:
          if (ctrl.update_ready) begin upd_go = 1'b1; state_nxt = S_UWAIT; end
        S_UWAIT:
          if (ctrl.update_ready) begin upd_done = 1'b1; state_nxt = S_IDLE; end
        S_PWR_OFF:
          if (ctrl.disp_off_ready) begin off_go = 1'b1; state_nxt = S_OFFW; end
        // Both power readies must be back so no command is still in flight.
        S_OFFW:
          if (ctrl.disp_on_ready && ctrl.disp_off_ready) state_nxt = S_OFF;
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= {(ROWS*COLS){SPACE}};
      shown       <= {(ROWS*COLS){SPACE}};
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      clear_pend  <= 1'b0;
      on_issued   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (text_valid) pend <= text_in;
      // Address/data are staged on entry to WRITE so they are stable with the pulse.
      if (load_char) begin
        row_q  <= ld_row;
        col_q  <= ld_col;
        addr_q <= {ld_row, ld_col, 3'b000};
        data_q <= char_at(FRAME_MAX_W'(pend), ROWS, COLS, int'(ld_row), int'(ld_col));
      end
      if (char_done)
        shown[((ROWS-1-int'(row_q))*COLS + COLS-1-int'(col_q))*CHAR_PX +: CHAR_PX] <= data_q;
      if (upd_go) clear_pend <= 1'b0;
      if (clear_req && state != S_OFF) clear_pend <= 1'b1;
      if (upd_done) frame_count <= frame_count + 16'd1;
      if (on_go) on_issued <= 1'b1;
    end
  end

  assign ctrl.write_start      = wr_go;
  assign ctrl.write_base_addr  = addr_q;
  assign ctrl.write_ascii_data = data_q;
  assign ctrl.update_start     = upd_go;
  assign ctrl.update_clear     = upd_go & clear_pend;
  assign ctrl.disp_on_start    = on_go;
  assign ctrl.disp_off_start   = off_go;
  assign busy = !(state == S_IDLE || state == S_OFF);

endmodule

// File: tb/tb_oled_text_refresher.sv
// Directed bench for oled_text_refresher with a behavioural OLEDCtrl model and
// expected/observed command queues.
module tb_oled_text_refresher;
  import oled_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 16;
  localparam int FW   = ROWS * COLS * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [FW-1:0] text_in;
  logic [FW-1:0] frame;
  logic text_valid = 1'b0, force_update = 1'b0, clear_req = 1'b0, disp_enable = 1'b1;
  logic busy;
  logic [ROWS-1:0] dirty_rows;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  oled_text_refresher_if c();

  oled_text_refresher #(.ROWS(ROWS), .COLS(COLS), .AUTO_START(1'b1), .AUTO_UPDATE(1'b1)) dut (
    .clk(clk), .rst(rst), .text_in(text_in), .text_valid(text_valid),
    .force_update(force_update), .clear_req(clear_req), .disp_enable(disp_enable),
    .ctrl(c), .busy(busy), .dirty_rows(dirty_rows), .frame_count(frame_count)
  );

  // OLEDCtrl model: ready drops after a start for 3..20 cycles; never reset.
  logic wr_rdy = 1'b1, up_rdy = 1'b1, on_rdy = 1'b1, off_rdy = 1'b1;
  int wr_cnt = 0, up_cnt = 0, on_cnt_m = 0, off_cnt_m = 0, proto_err = 0;
  assign c.write_ready    = wr_rdy;
  assign c.update_ready   = up_rdy;
  assign c.disp_on_ready  = on_rdy;
  assign c.disp_off_ready = off_rdy;

  always @(posedge clk) begin
    if (c.write_start) begin
      if (!wr_rdy) proto_err <= proto_err + 1;
      wr_rdy <= 1'b0; wr_cnt <= $urandom_range(3, 20);
    end else if (!wr_rdy) begin
      if (wr_cnt <= 1) wr_rdy <= 1'b1;
      wr_cnt <= wr_cnt - 1;
    end
    if (c.update_start) begin
      if (!up_rdy) proto_err <= proto_err + 1;
      up_rdy <= 1'b0; up_cnt <= $urandom_range(3, 20);
    end else if (!up_rdy) begin
      if (up_cnt <= 1) up_rdy <= 1'b1;
      up_cnt <= up_cnt - 1;
    end
    if (c.disp_on_start) begin
      if (!on_rdy) proto_err <= proto_err + 1;
      on_rdy <= 1'b0; on_cnt_m <= $urandom_range(3, 20);
    end else if (!on_rdy) begin
      if (on_cnt_m <= 1) on_rdy <= 1'b1;
      on_cnt_m <= on_cnt_m - 1;
    end
    if (c.disp_off_start) begin
      if (!off_rdy) proto_err <= proto_err + 1;
      off_rdy <= 1'b0; off_cnt_m <= $urandom_range(3, 20);
    end else if (!off_rdy) begin
      if (off_cnt_m <= 1) off_rdy <= 1'b1;
      off_cnt_m <= off_cnt_m - 1;
    end
  end

  // Observed commands, sampled on the falling edge.
  logic [16:0] obs_w[$];
  logic        obs_u[$];
  int on_cnt = 0, off_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (c.write_start)    obs_w.push_back({c.write_base_addr, c.write_ascii_data});
      if (c.update_start)   obs_u.push_back(c.update_clear);
      if (c.disp_on_start)  on_cnt  <= on_cnt + 1;
      if (c.disp_off_start) off_cnt <= off_cnt + 1;
    end
  end

  logic [16:0] exp_w[$];
  logic        exp_u[$];
  int rd_w = 0, rd_u = 0;
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fch(input logic [FW-1:0] f, input int r, input int cc);
    return f[((ROWS - 1 - r) * COLS + COLS - 1 - cc) * 8 +: 8];
  endfunction

  task automatic set_row(input int r, input string s);
    for (int cc = 0; cc < COLS; cc++)
      frame[((ROWS - 1 - r) * COLS + COLS - 1 - cc) * 8 +: 8] = (cc < s.len()) ? s[cc] : 8'h20;
  endtask

  task automatic push_row(input int r);
    for (int cc = 0; cc < COLS; cc++)
      exp_w.push_back({2'(r), 4'(cc), 3'b000, fch(frame, r, cc)});
  endtask

  task automatic strobe_text();
    @(negedge clk); text_in = frame; text_valid = 1'b1;
    @(negedge clk); text_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int q = 0;
    int n = 0;
    while (q < 4 && n < 6000) begin
      @(negedge clk); n++;
      if (!busy && dirty_rows == '0) q++; else q = 0;
    end
    chk({tag, "_settle"}, 32'(q), 32'd4);
  endtask

  task automatic wait_writes(input int k);
    int n = 0;
    while (obs_w.size() < rd_w + k && n < 3000) begin @(negedge clk); n++; end
    chk("write_progress", 32'(obs_w.size() >= rd_w + k), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    logic [16:0] e;
    while (exp_w.size() > 0) begin
      e = exp_w.pop_front();
      if (rd_w < obs_w.size()) begin chk(tag, 32'(obs_w[rd_w]), 32'(e)); rd_w++; end
      else chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
    end
    chk({tag, "_extra"}, 32'(obs_w.size() - rd_w), 32'd0);
    rd_w = obs_w.size();
  endtask

  task automatic check_upds(input string tag);
    logic e;
    while (exp_u.size() > 0) begin
      e = exp_u.pop_front();
      if (rd_u < obs_u.size()) begin chk(tag, 32'(obs_u[rd_u]), 32'(e)); rd_u++; end
      else chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
    end
    chk({tag, "_extra"}, 32'(obs_u.size() - rd_u), 32'd0);
    rd_u = obs_u.size();
  endtask

  initial begin
    frame   = {(ROWS*COLS){8'h20}};
    text_in = frame;
    repeat (3) @(negedge clk);
    chk("rst_starts", {c.write_start, c.update_start, c.update_clear, c.disp_on_start, c.disp_off_start}, 0);
    chk("rst_addr", c.write_base_addr, 0);
    chk("rst_data", c.write_ascii_data, 0);
    chk("rst_dirty", dirty_rows, 4'b1111);
    chk("rst_frames", frame_count, 0);
    rst = 1'b0;

    // Power-on and full initial paint.
    for (int r = 0; r < ROWS; r++) push_row(r);
    exp_u.push_back(1'b0);
    wait_idle("t1");
    check_writes("t1_wr"); check_upds("t1_upd");
    chk("t1_on", on_cnt, 1);
    chk("t1_frames", frame_count, 1);

    // Only row 2 changes.
    set_row(2, "HELLO");
    strobe_text();
    chk("t2_dirty", dirty_rows, 4'b0100);
    push_row(2); exp_u.push_back(1'b0);
    wait_idle("t2");
    check_writes("t2_wr"); check_upds("t2_upd");
    chk("t2_frames", frame_count, 2);

    // Row 1 changes while row 2 is being written.
    set_row(2, "JELLO");
    strobe_text();
    push_row(2);
    wait_writes(3);
    set_row(1, "ROW1");
    strobe_text();
    chk("t3_dirty", dirty_rows, 4'b0010);
    push_row(1); exp_u.push_back(1'b0);
    wait_idle("t3");
    check_writes("t3_wr"); check_upds("t3_upd");
    chk("t3_frames", frame_count, 3);

    // Clear: an update with clear set and no writes.
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    exp_u.push_back(1'b1);
    wait_idle("t4c");
    check_writes("t4c_wr"); check_upds("t4c_upd");
    chk("t4c_frames", frame_count, 4);

    // Forced refresh together with new text.
    set_row(0, "ABC");
    @(negedge clk); text_in = frame; text_valid = 1'b1; force_update = 1'b1;
    @(negedge clk); text_valid = 1'b0; force_update = 1'b0;
    chk("t4f_dirty", dirty_rows, 4'b1111);
    for (int r = 0; r < ROWS; r++) push_row(r);
    exp_u.push_back(1'b0);
    wait_idle("t4f");
    check_writes("t4f_wr"); check_upds("t4f_upd");
    chk("t4f_frames", frame_count, 5);

    // Power down mid-row: row and update finish first.
    set_row(3, "Z");
    strobe_text();
    push_row(3); exp_u.push_back(1'b0);
    wait_writes(2);
    disp_enable = 1'b0;
    wait_idle("t5off");
    check_writes("t5_wr"); check_upds("t5_upd");
    chk("t5_off", off_cnt, 1);
    chk("t5_frames", frame_count, 6);
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    repeat (5) @(negedge clk);
    disp_enable = 1'b1;
    for (int n = 0; n < 200 && on_cnt < 2; n++) @(negedge clk);
    chk("t5_on", on_cnt, 2);
    wait_idle("t5on");
    check_writes("t5on_wr"); check_upds("t5on_upd");
    chk("t5on_frames", frame_count, 6);

    // Reset while a write is outstanding.
    @(negedge clk); force_update = 1'b1;
    @(negedge clk); force_update = 1'b0;
    wait_writes(2);
    for (int n = 0; n < 200 && !( !c.write_ready && busy); n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_starts", {c.write_start, c.update_start, c.disp_on_start, c.disp_off_start}, 0);
    chk("t6_dirty", dirty_rows, 4'b1111);
    chk("t6_frames", frame_count, 0);
    chk("t6_addr", c.write_base_addr, 0);
    rd_w = obs_w.size(); rd_u = obs_u.size();
    exp_w.delete(); exp_u.delete();
    rst = 1'b0;
    frame = {(ROWS*COLS){8'h20}};
    for (int r = 0; r < ROWS; r++) push_row(r);
    exp_u.push_back(1'b0);
    wait_idle("t6");
    check_writes("t6_wr"); check_upds("t6_upd");
    chk("t6_frames_after", frame_count, 1);
    chk("protocol", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
